// File: rtl/uart_reg_master_if.sv
// Command/response handshake plus register-bus signals for uart_reg_master.
// master = the register master block, slave = the command source and register bus around it.
interface uart_reg_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [11:0] waddr;
    logic [11:0] raddr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        wack;
    logic        rack;
    logic        waddrerr;
    logic        raddrerr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  rdata, wack, rack, waddrerr, raddrerr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output waddr, raddr, wdata, wr_en, rd_en
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output rdata, wack, rack, waddrerr, raddrerr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  waddr, raddr, wdata, wr_en, rd_en
    );
endinterface

// File: rtl/uart_reg_master.sv
// Single-outstanding register bus master: one command in, one strobe out, one response back.
// Latency: response 2 cycles after accept when acked in REQ; 3-cycle minimum command period.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. Timeout under UART_REG_MASTER_TIMEOUT_EN.
module uart_reg_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_reg_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ADDR    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("uart_reg_master: TIMEOUT_CYCLES out of range 2..255");
        end
    endgenerate

    state_t state;
    state_t state_next;
    logic   op_write;
    logic   ack_hit;
    logic   err_hit;
    logic   bus_phase;
    logic   timeout_hit;

    assign ack_hit   = op_write ? bus.wack     : bus.rack;
    assign err_hit   = op_write ? bus.waddrerr : bus.raddrerr;
    assign bus_phase = (state == REQ) || (state == WAIT);

`ifdef UART_REG_MASTER_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // wait_cnt is the number of WAIT cycles already completed before this edge.
    assign timeout_hit = (state == WAIT) && !ack_hit && !err_hit &&
                         (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (state == REQ) begin
            wait_cnt <= 8'd0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_next = REQ;
            end
            REQ: begin
                bus.wr_en  = op_write;
                bus.rd_en  = !op_write;
                state_next = (ack_hit || err_hit) ? RESP : WAIT;
            end
            WAIT: begin
                if (ack_hit || err_hit || timeout_hit) state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/data registers only load on accept, so they stay put through REQ and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write      <= 1'b0;
            bus.waddr     <= 12'd0;
            bus.raddr     <= 12'd0;
            bus.wdata     <= 32'd0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= ERR_OK;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                op_write <= bus.cmd_write;
                if (bus.cmd_write) begin
                    bus.waddr <= bus.cmd_addr;
                    bus.wdata <= bus.cmd_wdata;
                end else begin
                    bus.raddr <= bus.cmd_addr;
                end
            end
            if (bus_phase && (ack_hit || err_hit)) begin
                bus.rsp_err   <= err_hit ? ERR_ADDR : ERR_OK;
                bus.rsp_rdata <= (err_hit || op_write) ? 32'd0 : bus.rdata;
            end else if (timeout_hit) begin
                bus.rsp_err   <= ERR_TIMEOUT;
                bus.rsp_rdata <= 32'd0;
            end
        end
    end

endmodule
